// File: rtl/rtl_handshake_source_if.sv
// rtl/rtl_handshake_source_if.sv - ready/valid bundle between the handshake source and its upstream/consumers
// master is the source's view; slave is the producer/consumer side that faces it.
interface rtl_handshake_source_if #(
   parameter int WIDTH = 4,
   parameter int LANES = 3
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in1;
   logic [WIDTH-1:0]     in2;
   logic                 handshake_valid;
   logic                 handshake_ready;
   logic [LANES-1:0]     handshake_arr_valid;
   logic [LANES-1:0]     handshake_arr_ready;
   logic                 out;
   logic [2*WIDTH-1:0]   out_data;

   modport master (
      input  in_valid, in1, in2, handshake_ready, handshake_arr_ready,
      output in_ready, handshake_valid, handshake_arr_valid, out, out_data
   );

   modport slave (
      output in_valid, in1, in2, handshake_ready, handshake_arr_ready,
      input  in_ready, handshake_valid, handshake_arr_valid, out, out_data
   );
endinterface

// File: rtl/rtl_handshake_source.sv
// rtl/rtl_handshake_source.sv - FIFO-buffered producer forking each head entry to one primary and LANES consumers
// An entry retires once every consumer has accepted it; head payload is held in registers.
module rtl_handshake_source #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2,
   parameter int LANES = 3
) (
   input  logic                  CLK,
   input  logic                  ASYNCRESETN,
   rtl_handshake_source_if.master hs
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int DW = 2 * WIDTH;
   localparam int EW = DW + 1;

   logic [EW-1:0]    storage [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             prim_done;
   logic [LANES-1:0] lane_done;
   logic             in_ready_q;
   logic             out_q;
   logic [DW-1:0]    data_q;

   logic             empty;
   logic             push;
   logic             retire;
   logic             prim_acc;
   logic [LANES-1:0] lane_acc;
   logic [EW-1:0]    push_entry;
   logic [EW-1:0]    head_next;
   logic [PW-1:0]    rd_ptr_next;
   logic [CW-1:0]    count_next;
   logic [CW-1:0]    remain;

   assign empty   = (count == '0);
   assign push    = hs.in_valid & in_ready_q;

   assign hs.in_ready            = in_ready_q;
   assign hs.handshake_valid     = !empty & !prim_done;
   assign hs.handshake_arr_valid = {LANES{!empty}} & ~lane_done;
   assign hs.out                 = out_q;
   assign hs.out_data            = data_q;

   assign prim_acc = hs.handshake_valid & hs.handshake_ready;
   assign lane_acc = hs.handshake_arr_valid & hs.handshake_arr_ready;

   // Retire when every consumer has accepted, whether earlier or right now.
   assign retire = !empty & (prim_done | prim_acc) & (&(lane_done | lane_acc));

   assign push_entry  = {hs.in2, hs.in1, (|hs.in1) & (&hs.in1)};
   assign rd_ptr_next = rd_ptr + PW'(retire);
   assign count_next  = count + CW'(push) - CW'(retire);
   assign remain      = count - CW'(retire);

   // The next head is either an already-stored entry or the one being pushed now.
   always_comb begin
      head_next = push_entry;
      if (remain != '0) begin
         head_next = storage[rd_ptr_next];
      end
   end

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         for (int i = 0; i < DEPTH; i++) begin
            storage[i] <= '0;
         end
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         prim_done  <= 1'b0;
         lane_done  <= '0;
         in_ready_q <= 1'b0;
         out_q      <= 1'b0;
         data_q     <= '0;
      end else begin
         if (push) begin
            storage[wr_ptr] <= push_entry;
            wr_ptr          <= wr_ptr + PW'(1);
         end

         rd_ptr     <= rd_ptr_next;
         count      <= count_next;
         in_ready_q <= (count_next != CW'(DEPTH));

         if (retire) begin
            prim_done <= 1'b0;
            lane_done <= '0;
         end else begin
            prim_done <= prim_done | prim_acc;
            lane_done <= lane_done | lane_acc;
         end

         // While empty the head registers keep their last value.
         if (count_next != '0) begin
            out_q  <= head_next[0];
            data_q <= head_next[EW-1:1];
         end
      end
   end
endmodule

// File: tb/tb_rtl_handshake_source.sv
// tb/tb_rtl_handshake_source.sv - directed vector bench for rtl_handshake_source
// Inputs change at negedge; outputs are sampled 1ns later.
module tb_rtl_handshake_source;
   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;

   rtl_handshake_source_if #(.WIDTH(4), .LANES(3)) hs ();

   rtl_handshake_source #(.WIDTH(4), .DEPTH(2), .LANES(3)) dut (
      .CLK         (clk),
      .ASYNCRESETN (rst_n),
      .hs          (hs.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       iv;
      logic [3:0] a;
      logic [3:0] b;
      logic       hr;
      logic [2:0] ar;
      logic [13:0] exp;
   } vec_t;

   vec_t vecs [22];

   function automatic vec_t mk(logic iv, logic [3:0] a, logic [3:0] b, logic hr, logic [2:0] ar,
                               logic ir, logic hv, logic [2:0] av, logic o, logic [7:0] od);
      vec_t r;
      r.iv = iv; r.a = a; r.b = b; r.hr = hr; r.ar = ar;
      r.exp = {ir, hv, av, o, od};
      return r;
   endfunction

   function automatic logic [13:0] observe();
      return {hs.in_ready, hs.handshake_valid, hs.handshake_arr_valid, hs.out, hs.out_data};
   endfunction

   task automatic chk(input string name, input logic [13:0] got, input logic [13:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got {ir,hv,av,out,od}=%b expected %b", name, got, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [3:0] a, input logic [3:0] b,
                        input logic hr, input logic [2:0] ar);
      hs.in_valid = iv;
      hs.in1 = a;
      hs.in2 = b;
      hs.handshake_ready = hr;
      hs.handshake_arr_ready = ar;
   endtask

   initial begin
      logic [7:0] exp_od;
      logic       exp_o;
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b0;
      drive(1'b0, 4'h0, 4'h0, 1'b0, 3'b000);

      vecs[0]  = mk(0, 4'h0, 4'h0, 1, 3'd7, 1, 0, 3'd0, 0, 8'h00);
      vecs[1]  = mk(1, 4'hF, 4'h3, 1, 3'd7, 1, 0, 3'd0, 0, 8'h00);
      vecs[2]  = mk(0, 4'h0, 4'h0, 1, 3'd7, 1, 1, 3'd7, 1, 8'h3F);
      vecs[3]  = mk(0, 4'h0, 4'h0, 1, 3'd7, 1, 0, 3'd0, 1, 8'h3F);
      vecs[4]  = mk(1, 4'h7, 4'h5, 1, 3'd7, 1, 0, 3'd0, 1, 8'h3F);
      vecs[5]  = mk(1, 4'h0, 4'hA, 1, 3'd7, 1, 1, 3'd7, 0, 8'h57);
      vecs[6]  = mk(0, 4'h0, 4'h0, 1, 3'd7, 1, 1, 3'd7, 0, 8'hA0);
      vecs[7]  = mk(0, 4'h0, 4'h0, 1, 3'd7, 1, 0, 3'd0, 0, 8'hA0);
      vecs[8]  = mk(1, 4'hC, 4'h1, 1, 3'd7, 1, 0, 3'd0, 0, 8'hA0);
      vecs[9]  = mk(0, 4'h0, 4'h0, 1, 3'd5, 1, 1, 3'd7, 0, 8'h1C);
      vecs[10] = mk(1, 4'hF, 4'h2, 1, 3'd5, 1, 0, 3'd2, 0, 8'h1C);
      vecs[11] = mk(0, 4'h0, 4'h0, 1, 3'd5, 0, 0, 3'd2, 0, 8'h1C);
      vecs[12] = mk(0, 4'h0, 4'h0, 1, 3'd7, 0, 0, 3'd2, 0, 8'h1C);
      vecs[13] = mk(0, 4'h0, 4'h0, 1, 3'd7, 1, 1, 3'd7, 1, 8'h2F);
      vecs[14] = mk(0, 4'h0, 4'h0, 0, 3'd0, 1, 0, 3'd0, 1, 8'h2F);
      vecs[15] = mk(1, 4'h1, 4'h1, 0, 3'd0, 1, 0, 3'd0, 1, 8'h2F);
      vecs[16] = mk(1, 4'h2, 4'h2, 0, 3'd0, 1, 1, 3'd7, 0, 8'h11);
      vecs[17] = mk(1, 4'hF, 4'h4, 0, 3'd0, 0, 1, 3'd7, 0, 8'h11);
      vecs[18] = mk(1, 4'hF, 4'h4, 1, 3'd7, 0, 1, 3'd7, 0, 8'h11);
      vecs[19] = mk(1, 4'hF, 4'h4, 1, 3'd7, 1, 1, 3'd7, 0, 8'h22);
      vecs[20] = mk(0, 4'h0, 4'h0, 1, 3'd7, 1, 1, 3'd7, 1, 8'h4F);
      vecs[21] = mk(0, 4'h0, 4'h0, 1, 3'd7, 1, 0, 3'd0, 1, 8'h4F);

      // Reset state and release timing
      repeat (2) @(posedge clk);
      #1 chk("reset_state", observe(), 14'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("ready_before_edge", observe(), 14'b0);
      @(posedge clk);
      #1 chk("ready_after_edge", observe(), {1'b1, 13'b0});

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].hr, vecs[i].ar);
         #1 chk($sformatf("vec%0d", i), observe(), vecs[i].exp);
      end

      // Streaming with continuous pops: pointers wrap, entries come out in order once each
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k < 6) drive(1'b1, 4'(k + 1), 4'(k + 8), 1'b1, 3'd7);
         else       drive(1'b0, 4'h0, 4'h0, 1'b1, 3'd7);
         if (k == 0) begin
            exp_od = 8'h4F;
            exp_o  = 1'b1;
         end else if (k < 7) begin
            exp_od = {4'(k + 7), 4'(k)};
            exp_o  = (4'(k) == 4'hF);
         end
         #1;
         if (k == 0 || k == 7) chk($sformatf("stream%0d", k), observe(), {1'b1, 1'b0, 3'd0, exp_o, exp_od});
         else                  chk($sformatf("stream%0d", k), observe(), {1'b1, 1'b1, 3'd7, exp_o, exp_od});
      end

      // Mid-cycle reset with two entries stored
      @(negedge clk);
      drive(1'b1, 4'hF, 4'h9, 1'b0, 3'd0);
      @(negedge clk);
      drive(1'b1, 4'h3, 4'h8, 1'b0, 3'd0);
      @(negedge clk);
      drive(1'b0, 4'h0, 4'h0, 1'b0, 3'd0);
      #1 chk("full_before_reset", observe(), {1'b0, 1'b1, 3'd7, 1'b1, 8'h9F});
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("async_reset", observe(), 14'b0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 4'h0, 4'h0, 1'b1, 3'd7);
      #1 chk("post_reset_release", observe(), 14'b0);
      @(negedge clk);
      #1 chk("post_reset_no_stale", observe(), {1'b1, 13'b0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
